// File: rtl/score_pkg.sv
// ============================================================================
// Module   : score_pkg
// Purpose  : Shared seven-segment constants and scan timing helper for the
//            score display controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic int dwell_count(input int clk_hz, input int refresh_hz,
                                       input int num_digits);
        int d;
        d = clk_hz / (refresh_hz * num_digits);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// Module   : bcd_to_7seg
// Purpose  : Combinational BCD to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import score_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_DIGIT[0];
            4'd1: o_seg = SEG_DIGIT[1];
            4'd2: o_seg = SEG_DIGIT[2];
            4'd3: o_seg = SEG_DIGIT[3];
            4'd4: o_seg = SEG_DIGIT[4];
            4'd5: o_seg = SEG_DIGIT[5];
            4'd6: o_seg = SEG_DIGIT[6];
            4'd7: o_seg = SEG_DIGIT[7];
            4'd8: o_seg = SEG_DIGIT[8];
            4'd9: o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/score_display_ctrl.sv
// ============================================================================
// Module   : score_display_ctrl
// Purpose  : N-digit BCD score counter with high-score retention and a
//            multiplexed active-low seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_display_ctrl
    import score_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_HZ        = 100000000,
    parameter int SCORE_TICK_HZ = 10,
    parameter int REFRESH_HZ    = 1000
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    score_clear,
    input  logic                    show_high,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    new_high,
    output logic                    overflow,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg
);

    localparam int c_SCORE_W  = 4 * NUM_DIGITS;
    localparam int c_TICK_DIV = (CLK_HZ / SCORE_TICK_HZ < 1) ? 1 : CLK_HZ / SCORE_TICK_HZ;
    localparam int c_TICK_W   = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int c_DWELL    = dwell_count(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int c_DWELL_W  = (c_DWELL > 1) ? $clog2(c_DWELL) : 1;
    localparam int c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(c_TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(c_DWELL - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

    logic [c_SCORE_W-1:0]  r_score;
    logic [c_SCORE_W-1:0]  r_high;
    logic                  r_new_high;
    logic                  r_overflow;
    logic                  r_run_d;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_DWELL_W-1:0]  r_dwell_cnt;
    logic [c_IDX_W-1:0]    r_scan_idx;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;

    logic [c_SCORE_W-1:0]  w_score_inc;
    logic                  w_all_nines;
    logic                  w_carry;
    logic                  w_tick;
    logic                  w_run_fall;
    logic [c_SCORE_W-1:0]  w_disp_val;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic                  w_upper_zero;
    logic [6:0]            w_seg_dec;

    assign w_tick     = run && (r_tick_cnt == c_TICK_LAST);
    assign w_run_fall = r_run_d && !run;

    // Ripple BCD increment; all-nines is detected separately so the score saturates
    always_comb begin
        w_score_inc = r_score;
        w_all_nines = 1'b1;
        w_carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_score[4*i +: 4] != 4'd9) w_all_nines = 1'b0;
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_overflow <= 1'b0;
            r_run_d    <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_run_d    <= run;
            r_new_high <= 1'b0;
            // Compare sees the pre-clear score even when a clear lands on the same edge
            if (w_run_fall && (r_score > r_high)) begin
                r_high     <= r_score;
                r_new_high <= 1'b1;
            end
            if (score_clear) begin
                r_score    <= '0;
                r_overflow <= 1'b0;
                r_tick_cnt <= '0;
            end else if (run) begin
                if (w_tick) begin
                    r_tick_cnt <= '0;
                    if (w_all_nines) r_overflow <= 1'b1;
                    else             r_score    <= w_score_inc;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    // Select the scanned digit and work out leading-zero blanking from the top down
    always_comb begin
        w_disp_val   = show_high ? r_high : r_score;
        w_digit      = 4'd0;
        w_blank      = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_disp_val[4*i +: 4] != 4'd0) w_upper_zero = 1'b0;
            if (c_IDX_W'(i) == r_scan_idx) begin
                w_digit = w_disp_val[4*i +: 4];
                w_blank = (i != 0) && w_upper_zero;
            end
        end
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_dwell_cnt <= '0;
            r_scan_idx  <= '0;
            r_anode     <= '1;
            r_seg       <= SEG_BLANK;
        end else begin
            if (r_dwell_cnt == c_DWELL_LAST) begin
                r_dwell_cnt <= '0;
                r_scan_idx  <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
            r_anode <= ~(NUM_DIGITS'(1) << r_scan_idx);
            r_seg   <= w_blank ? SEG_BLANK : w_seg_dec;
        end
    end

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign new_high  = r_new_high;
    assign overflow  = r_overflow;
    assign anode     = r_anode;
    assign seg       = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
// ============================================================================
// Module   : tb_score_display_ctrl
// Purpose  : Self-checking bench for score_display_ctrl with a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_display_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0, score_clear = 1'b0, show_high = 1'b0;
    logic [15:0] score_bcd, high_bcd;
    logic        new_high, overflow;
    logic [3:0]  anode;
    logic [6:0]  seg;

    logic        run2 = 1'b0, clear2 = 1'b0, show2 = 1'b0;
    logic [15:0] score2, high2;
    logic        new_high2, overflow2;
    logic [3:0]  anode2;
    logic [6:0]  seg2;

    int errors = 0;
    int checks = 0;

    score_display_ctrl #(.NUM_DIGITS(4), .CLK_HZ(1000), .SCORE_TICK_HZ(100), .REFRESH_HZ(50)) u_dut (
        .CLK(clk), .reset(rst_n), .run(run), .score_clear(score_clear), .show_high(show_high),
        .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high), .overflow(overflow),
        .anode(anode), .seg(seg)
    );

    // Tick every cycle so saturation is reachable in a short run
    score_display_ctrl #(.NUM_DIGITS(4), .CLK_HZ(1000), .SCORE_TICK_HZ(1000), .REFRESH_HZ(50)) u_dut_sat (
        .CLK(clk), .reset(rst_n), .run(run2), .score_clear(clear2), .show_high(show2),
        .score_bcd(score2), .high_bcd(high2), .new_high(new_high2), .overflow(overflow2),
        .anode(anode2), .seg(seg2)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal reference model of the main instance
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         m_score = 0, m_high = 0, m_phase = 0, m_edges = 0;
    int         m_idx, m_val, m_pw;
    bit         m_ovf = 0, m_pulse = 0, m_prev_run = 0;
    logic [3:0] m_anode = 4'hF;
    logic [6:0] m_seg   = 7'h7F;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score = 0; m_high = 0; m_phase = 0; m_edges = 0;
            m_ovf = 0; m_pulse = 0; m_prev_run = 0;
            m_anode = 4'hF; m_seg = 7'h7F;
        end else begin
            m_edges++;
            m_idx = ((m_edges - 1) / 5) % 4;
            m_val = show_high ? m_high : m_score;
            m_pw  = 1;
            for (int k = 0; k < m_idx; k++) m_pw = m_pw * 10;
            m_anode = ~(4'b0001 << m_idx);
            m_seg   = (m_idx > 0 && m_val / m_pw == 0) ? 7'h7F : seg_tbl[(m_val / m_pw) % 10];
            m_pulse = 0;
            if (m_prev_run && !run && m_score > m_high) begin
                m_high  = m_score;
                m_pulse = 1;
            end
            if (score_clear) begin
                m_score = 0; m_ovf = 0; m_phase = 0;
            end else if (run) begin
                m_phase++;
                if (m_phase == 10) begin
                    m_phase = 0;
                    if (m_score == 9999) m_ovf = 1;
                    else                 m_score++;
                end
            end
            m_prev_run = run;
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h expected 0000", score_bcd); end
        checks++; if (high_bcd !== 16'h0000) begin errors++; $display("FAIL reset_high: got %h expected 0000", high_bcd); end
        checks++; if (new_high !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got new_high=%b overflow=%b expected 0 0", new_high, overflow); end
        checks++; if (anode !== 4'hF || seg !== 7'h7F) begin errors++; $display("FAIL reset_display: got anode=%b seg=%h expected 1111 7f", anode, seg); end
        rst_n = 1'b1;
    endtask

    task automatic test_count_scan();
        logic [3:0] exp_an;
        run = 1'b1;
        for (int c = 1; c <= 125; c++) begin
            step();
            exp_an = ~(4'b0001 << (((c - 1) / 5) % 4));
            checks++; if (anode !== exp_an) begin errors++; $display("FAIL scan_anode cycle %0d: got %b expected %b", c, anode, exp_an); end
            checks++; if (seg !== m_seg) begin errors++; $display("FAIL scan_seg cycle %0d: got %h expected %h", c, seg, m_seg); end
            checks++; if (score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL count_score cycle %0d: got %h expected %h", c, score_bcd, to_bcd(m_score)); end
        end
        checks++; if (score_bcd !== 16'h0012 || overflow !== 1'b0) begin errors++; $display("FAIL count_125: got %h ovf=%b expected 0012 ovf=0", score_bcd, overflow); end
        run = 1'b0;
        step();
        checks++; if (new_high !== 1'b1 || high_bcd !== 16'h0012) begin errors++; $display("FAIL first_high: got high=%h pulse=%b expected 0012 1", high_bcd, new_high); end
    endtask

    task automatic test_saturate();
        run2 = 1'b1;
        repeat (9998) step();
        run2 = 1'b0;
        checks++; if (score2 !== 16'h9998) begin errors++; $display("FAIL sat_preload: got %h expected 9998", score2); end
        run2 = 1'b1;
        step();
        checks++; if (score2 !== 16'h9999) begin errors++; $display("FAIL sat_first: got %h expected 9999", score2); end
        repeat (2) step();
        run2 = 1'b0;
        checks++; if (score2 !== 16'h9999 || overflow2 !== 1'b1) begin errors++; $display("FAIL sat_hold: got %h ovf=%b expected 9999 ovf=1", score2, overflow2); end
        clear2 = 1'b1;
        step();
        clear2 = 1'b0;
        checks++; if (score2 !== 16'h0000 || overflow2 !== 1'b0) begin errors++; $display("FAIL sat_clear: got %h ovf=%b expected 0000 ovf=0", score2, overflow2); end
    endtask

    task automatic test_high_score();
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1;
        repeat (420) step();
        checks++; if (score_bcd !== 16'h0042) begin errors++; $display("FAIL game1_score: got %h expected 0042", score_bcd); end
        run = 1'b0;
        step();
        checks++; if (high_bcd !== 16'h0042 || new_high !== 1'b1) begin errors++; $display("FAIL game1_high: got high=%h pulse=%b expected 0042 1", high_bcd, new_high); end
        step();
        checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL game1_pulse_len: got %b expected 0", new_high); end
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1;
        repeat (420) step();
        run = 1'b0;
        step();
        checks++; if (new_high !== 1'b0 || high_bcd !== 16'h0042) begin errors++; $display("FAIL tie_no_update: got high=%h pulse=%b expected 0042 0", high_bcd, new_high); end
        step();
        checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL tie_pulse_late: got %b expected 0", new_high); end
    endtask

    task automatic test_clear_fall();
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1;
        repeat (500) step();
        run = 1'b0;
        score_clear = 1'b1;
        step();
        score_clear = 1'b0;
        checks++; if (high_bcd !== 16'h0050 || score_bcd !== 16'h0000) begin errors++; $display("FAIL clear_fall: got high=%h score=%h expected 0050 0000", high_bcd, score_bcd); end
        checks++; if (new_high !== 1'b1) begin errors++; $display("FAIL clear_fall_pulse: got %b expected 1", new_high); end
    endtask

    task automatic test_display();
        logic [6:0] exp_seg;
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1; repeat (70) step(); run = 1'b0; step();
        show_high = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            exp_seg = (anode == 4'b1110) ? 7'h78 : 7'h7F;
            checks++; if (seg !== exp_seg || $countones(~anode) != 1) begin errors++; $display("FAIL blank_seven: anode=%b got %h expected %h", anode, seg, exp_seg); end
        end
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1; repeat (1200) step(); run = 1'b0; step();
        score_clear = 1'b1; step(); score_clear = 1'b0;
        show_high = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            step();
            case (anode)
                4'b1110: exp_seg = 7'h40;
                4'b1101: exp_seg = 7'h24;
                4'b1011: exp_seg = 7'h79;
                default: exp_seg = 7'h7F;
            endcase
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL show_high_0120: anode=%b got %h expected %h", anode, seg, exp_seg); end
        end
        show_high = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            score_clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 14) == 0) show_high = ~show_high;
            step();
            checks++;
            if (score_bcd !== to_bcd(m_score) || high_bcd !== to_bcd(m_high) || new_high !== m_pulse ||
                overflow !== m_ovf || anode !== m_anode || seg !== m_seg) begin
                errors++;
                $display("FAIL random cycle %0d: got score=%h high=%h pulse=%b ovf=%b an=%b seg=%h expected %h %h %b %b %b %h",
                         c, score_bcd, high_bcd, new_high, overflow, anode, seg,
                         to_bcd(m_score), to_bcd(m_high), m_pulse, m_ovf, m_anode, m_seg);
            end
        end
        run = 1'b0; score_clear = 1'b0; show_high = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        score_clear = 1'b1; step(); score_clear = 1'b0;
        run = 1'b1;
        repeat (330) step();
        checks++; if (score_bcd !== 16'h0033) begin errors++; $display("FAIL pre_reset_score: got %h expected 0033", score_bcd); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (score_bcd !== 16'h0000 || high_bcd !== 16'h0000 || new_high !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: got score=%h high=%h pulse=%b ovf=%b expected all 0", score_bcd, high_bcd, new_high, overflow);
        end
        checks++; if (anode !== 4'hF || seg !== 7'h7F) begin errors++; $display("FAIL async_reset_display: got anode=%b seg=%h expected 1111 7f", anode, seg); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        checks++; if (score_bcd !== 16'h0001 || score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL restart_count: got %h expected 0001", score_bcd); end
        checks++; if (anode !== 4'b1101) begin errors++; $display("FAIL restart_scan: got %b expected 1101", anode); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_scan();
        test_saturate();
        test_high_score();
        test_clear_fall();
        test_display();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
